// File: rtl/acc_seq_pkg.sv
// acc_sequencer shared definitions:
// opcodes, ALU encodings, FSM states and opcode helpers.
package acc_seq_pkg;

    localparam int OPC_W = 8;
    localparam int ALU_W = 4;

    localparam logic [OPC_W-1:0] OP_STORE = 8'h01;
    localparam logic [OPC_W-1:0] OP_LOAD  = 8'h02;
    localparam logic [OPC_W-1:0] OP_ADD   = 8'h03;
    localparam logic [OPC_W-1:0] OP_SUB   = 8'h04;
    localparam logic [OPC_W-1:0] OP_MPY   = 8'h05;
    localparam logic [OPC_W-1:0] OP_AND   = 8'h06;
    localparam logic [OPC_W-1:0] OP_OR    = 8'h07;
    localparam logic [OPC_W-1:0] OP_NOT   = 8'h08;
    localparam logic [OPC_W-1:0] OP_SHL   = 8'h09;
    localparam logic [OPC_W-1:0] OP_SHR   = 8'h0A;
    localparam logic [OPC_W-1:0] OP_MPYH  = 8'h0B;

    // ALU select is the opcode's low nibble
    localparam logic [ALU_W-1:0] ALU_NONE = 4'h0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'h3;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'h4;
    localparam logic [ALU_W-1:0] ALU_MPY  = 4'h5;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'h6;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'h7;
    localparam logic [ALU_W-1:0] ALU_NOT  = 4'h8;
    localparam logic [ALU_W-1:0] ALU_SHL  = 4'h9;
    localparam logic [ALU_W-1:0] ALU_SHR  = 4'hA;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MEM_RD,
        S_MEM_WR,
        S_LOAD_ACC,
        S_ALU_EXEC,
        S_ALU_WAIT,
        S_WB_BR,
        S_WB_MR,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return (op >= OP_STORE) && (op <= OP_MPYH);
    endfunction

    function automatic logic needs_mem_rd(input logic [OPC_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_MPY)  || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_multicycle(input logic [OPC_W-1:0] op);
        return op == OP_MPY;
    endfunction

endpackage

// File: rtl/acc_seq_wait_timer.sv
// Memory wait counter: cleared outside memory states,
// counts cycles without ready and flags the timeout cycle.
module acc_seq_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(LIMIT - 1));

    // next count: clear wins, saturate at the timeout value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acc_sequencer.sv
// Execute-phase sequencer for the accumulator datapath:
// opcode-driven multi-cycle control of ACC/ALU/MBR/MR.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int OPCODE_W    = 8,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    input  logic                i_alu_done,
    output logic                o_c7,
    output logic                o_c9,
    output logic                o_c10,
    output logic                o_c11,
    output logic                o_c12,
    output logic                o_alu_en,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_mem_rd,
    output logic                o_mem_wr,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    state_e              state_q;
    state_e              state_d;
    logic [OPCODE_W-1:0] opc_q;
    logic [OPCODE_W-1:0] opc_d;
    logic                in_mem;
    logic                expired;

    assign in_mem = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    acc_seq_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clr     (!in_mem),
        .en      (in_mem && !i_mem_ready),
        .expired (expired)
    );

    // state and latched opcode
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    // next-state sequencing per opcode
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    opc_d = i_opcode;
                    if (!is_legal(i_opcode)) begin
                        state_d = S_ERR;
                    end else if (i_opcode == OP_STORE) begin
                        state_d = S_MEM_WR;
                    end else if (i_opcode == OP_MPYH) begin
                        state_d = S_WB_MR;
                    end else if (needs_mem_rd(i_opcode)) begin
                        state_d = S_MEM_RD;
                    end else begin
                        state_d = S_ALU_EXEC;
                    end
                end
            end
            S_MEM_RD: begin
                if (i_mem_ready) begin
                    state_d = (opc_q == OP_LOAD) ? S_LOAD_ACC : S_ALU_EXEC;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_MEM_WR: begin
                if (i_mem_ready) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_LOAD_ACC: state_d = S_DONE;
            S_ALU_EXEC: begin
                state_d = is_multicycle(opc_q) ? S_ALU_WAIT : S_WB_BR;
            end
            S_ALU_WAIT: begin
                if (i_alu_done) begin
                    state_d = S_WB_BR;
                end
            end
            S_WB_BR: state_d = S_DONE;
            S_WB_MR: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state
    always_comb begin
        o_c7     = 1'b0;
        o_c9     = 1'b0;
        o_c10    = 1'b0;
        o_c11    = 1'b0;
        o_c12    = 1'b0;
        o_alu_en = 1'b0;
        o_alu_op = '0;
        o_mem_rd = 1'b0;
        o_mem_wr = 1'b0;
        o_busy   = (state_q != S_IDLE);
        o_done   = 1'b0;
        o_error  = 1'b0;
        unique case (state_q)
            S_MEM_RD: o_mem_rd = 1'b1;
            S_MEM_WR: begin
                o_mem_wr = 1'b1;
                o_c12    = 1'b1;
            end
            S_LOAD_ACC: o_c11 = 1'b1;
            S_ALU_EXEC: begin
                o_c7     = 1'b1;
                o_alu_en = 1'b1;
                o_alu_op = opc_q[ALU_OP_W-1:0];
            end
            S_ALU_WAIT: begin
                o_c7     = 1'b1;
                o_alu_op = opc_q[ALU_OP_W-1:0];
            end
            S_WB_BR: o_c9    = 1'b1;
            S_WB_MR: o_c10   = 1'b1;
            S_DONE:  o_done  = 1'b1;
            S_ERR:   o_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: vector table
// per opcode plus reset / back-to-back sequences.
module tb_acc_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_opcode;
    logic       i_mem_ready;
    logic       i_alu_done;
    logic       o_c7, o_c9, o_c10, o_c11, o_c12;
    logic       o_alu_en;
    logic [3:0] o_alu_op;
    logic       o_mem_rd, o_mem_wr;
    logic       o_busy, o_done, o_error;

    int total = 0;
    int bad   = 0;
    int onehot_bad = 0;
    logic [15:0] acc = 16'h0000;
    logic [15:0] mbr = 16'hBEEF;

    acc_sequencer #(
        .OPCODE_W    (8),
        .ALU_OP_W    (4),
        .MEM_TIMEOUT (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_opcode    (i_opcode),
        .i_mem_ready (i_mem_ready),
        .i_alu_done  (i_alu_done),
        .o_c7        (o_c7),
        .o_c9        (o_c9),
        .o_c10       (o_c10),
        .o_c11       (o_c11),
        .o_c12       (o_c12),
        .o_alu_en    (o_alu_en),
        .o_alu_op    (o_alu_op),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if ($countones({o_c9, o_c10, o_c11}) > 1 ||
            (o_c12 && (o_c9 || o_c10 || o_c11)))
            onehot_bad++;
    end

    function automatic int all_outs();
        return int'({o_c7, o_c9, o_c10, o_c11, o_c12, o_alu_en,
                     o_alu_op, o_mem_rd, o_mem_wr, o_busy,
                     o_done, o_error});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] op;
        int rdy;
        int alu;
        int inj;
        int lat;
        bit err;
        int n_rd;
        int n_wr;
        int n_c7;
        int n_en;
        int n_c9;
        int n_c10;
        int n_c11;
        int n_c12;
        int aop;
    } vec_t;

    vec_t vecs[13];

    task automatic run_vec(input vec_t v, input int idx);
        int n, memcnt, waitcnt, done_at, err_at, leak;
        int nrd, nwr, nc7, nen, nc9, nc10, nc11, nc12, aop;
        bit fin;
        string p;
        p = $sformatf("v%0d_op%02h", idx, v.op);
        n = 0; memcnt = 0; waitcnt = 0; done_at = 0; err_at = 0;
        leak = 0; nrd = 0; nwr = 0; nc7 = 0; nen = 0; nc9 = 0;
        nc10 = 0; nc11 = 0; nc12 = 0; aop = 0; fin = 1'b0;
        @(negedge i_clk);
        i_start  = 1'b1;
        i_opcode = v.op;
        tick();
        i_start  = 1'b0;
        i_opcode = 8'h00;
        while (!fin && n < 100) begin
            n++;
            if (o_mem_rd) nrd++;
            if (o_mem_wr) nwr++;
            if (o_c7) nc7++;
            if (o_alu_en) nen++;
            if (o_c9) nc9++;
            if (o_c10) nc10++;
            if (o_c11) begin nc11++; acc = mbr; end
            if (o_c12) nc12++;
            if (o_c7) aop = int'(o_alu_op);
            else if (o_alu_op != 4'h0) leak++;
            if (o_done) begin done_at = n; fin = 1'b1; end
            if (o_error) begin err_at = n; fin = 1'b1; end
            if (o_mem_rd || o_mem_wr) begin
                i_mem_ready = (memcnt >= v.rdy);
                memcnt++;
            end else begin
                i_mem_ready = 1'b0;
                memcnt = 0;
            end
            if (o_c7 && !o_alu_en) begin
                waitcnt++;
                i_alu_done = (waitcnt == v.alu);
            end else begin
                i_alu_done = 1'b0;
            end
            i_start  = (v.inj != 0) && (n == v.inj);
            i_opcode = i_start ? 8'h02 : 8'h00;
            tick();
        end
        i_mem_ready = 1'b0;
        i_alu_done  = 1'b0;
        i_start     = 1'b0;
        chk({p, "_finished"}, int'(fin), 1);
        chk({p, "_lat"}, v.err ? err_at : done_at, v.lat);
        chk({p, "_done_seen"}, int'(done_at != 0), int'(!v.err));
        chk({p, "_n_rd"}, nrd, v.n_rd);
        chk({p, "_n_wr"}, nwr, v.n_wr);
        chk({p, "_n_c7"}, nc7, v.n_c7);
        chk({p, "_n_alu_en"}, nen, v.n_en);
        chk({p, "_n_c9"}, nc9, v.n_c9);
        chk({p, "_n_c10"}, nc10, v.n_c10);
        chk({p, "_n_c11"}, nc11, v.n_c11);
        chk({p, "_n_c12"}, nc12, v.n_c12);
        chk({p, "_alu_op"}, aop, v.aop);
        chk({p, "_alu_op_leak"}, leak, 0);
        chk({p, "_idle_after"}, int'(o_busy), 0);
        tick();
        chk({p, "_no_requeue"}, int'(o_busy), 0);
    endtask

    initial begin
        int ndone;
        //        op     rdy   alu inj lat err rd wr c7 en c9 c10 c11 c12 aop
        vecs[0]  = '{8'h02, 0,    0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 1, 0,  0};
        vecs[1]  = '{8'h01, 1,    0, 0,  3, 0, 0, 2, 0, 0, 0, 0, 0, 2,  0};
        vecs[2]  = '{8'h03, 2,    0, 0,  6, 0, 3, 0, 1, 1, 1, 0, 0, 0,  3};
        vecs[3]  = '{8'h04, 0,    0, 0,  4, 0, 1, 0, 1, 1, 1, 0, 0, 0,  4};
        vecs[4]  = '{8'h06, 0,    0, 0,  4, 0, 1, 0, 1, 1, 1, 0, 0, 0,  6};
        vecs[5]  = '{8'h07, 1,    0, 0,  5, 0, 2, 0, 1, 1, 1, 0, 0, 0,  7};
        vecs[6]  = '{8'h08, 0,    0, 0,  3, 0, 0, 0, 1, 1, 1, 0, 0, 0,  8};
        vecs[7]  = '{8'h09, 0,    0, 0,  3, 0, 0, 0, 1, 1, 1, 0, 0, 0,  9};
        vecs[8]  = '{8'h0A, 0,    0, 0,  3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 10};
        vecs[9]  = '{8'h05, 0,    1, 0,  5, 0, 1, 0, 2, 1, 1, 0, 0, 0,  5};
        vecs[10] = '{8'h05, 0,    4, 4,  8, 0, 1, 0, 5, 1, 1, 0, 0, 0,  5};
        vecs[11] = '{8'h01, 1000, 0, 0, 17, 1, 0, 16, 0, 0, 0, 0, 0, 16, 0};
        vecs[12] = '{8'h0C, 0,    0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0};

        i_rst = 1'b1; i_start = 1'b0; i_opcode = 8'h00;
        i_mem_ready = 1'b0; i_alu_done = 1'b0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 0);
        i_rst = 1'b0;
        tick();
        chk("idle_outputs", all_outs(), 0);

        // reset in the middle of a LOAD memory wait
        @(negedge i_clk);
        i_start = 1'b1; i_opcode = 8'h02;
        tick();
        i_start = 1'b0; i_opcode = 8'h00;
        chk("midrst_rd_c1", int'(o_mem_rd), 1);
        tick();
        tick();
        chk("midrst_rd_c3", int'(o_mem_rd), 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst_outputs", all_outs(), 0);
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_done || o_busy) ndone++;
            tick();
        end
        chk("midrst_quiet", ndone, 0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) chk("acc_after_load", int'(acc), 16'hBEEF);
        end

        // illegal opcode then MPYH back-to-back
        @(negedge i_clk);
        i_start = 1'b1; i_opcode = 8'hFF;
        tick();
        i_start = 1'b0; i_opcode = 8'h00;
        chk("ill_error", int'(o_error), 1);
        chk("ill_clines", int'({o_c7, o_c9, o_c10, o_c11, o_c12}), 0);
        chk("ill_done", int'(o_done), 0);
        tick();
        chk("ill_idle", int'({o_busy, o_error}), 0);
        i_start = 1'b1; i_opcode = 8'h0B;
        tick();
        i_start = 1'b0; i_opcode = 8'h00;
        chk("mpyh_c10", int'(o_c10), 1);
        tick();
        chk("mpyh_done", int'(o_done), 1);
        chk("mpyh_c10_off", int'(o_c10), 0);
        tick();
        chk("mpyh_idle", int'(o_busy), 0);

        chk("onehot_c9_c10_c11_c12", onehot_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Execute-phase sequencer for the 16-bit accumulator datapath. On a start pulse from the main control unit it decodes the current opcode and drives the accumulator control lines (C7, C9–C12), ALU enable/op and the memory read/write handshake over a fixed multi-cycle sequence. When the sequence completes it returns a one-cycle done pulse. It sits between the instruction decoder/main FSM and the ACC/ALU/MBR/MR registers.

## Interface
- `OPCODE_W`, 8, opcode width
- `ALU_OP_W`, 4, ALU operation select width
- `MEM_TIMEOUT`, 16, maximum cycles to wait for `i_mem_ready` before aborting (≥2)
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_start`  in  1  one-cycle request to execute `i_opcode`; honoured only in IDLE
- `i_opcode`  in  OPCODE_W  opcode, sampled only in the cycle `i_start` is accepted
- `i_mem_ready`  in  1  memory acknowledge for the current read/write
- `i_alu_done`  in  1  multi-cycle ALU result valid
- `o_c7`, `o_c9`, `o_c10`, `o_c11`, `o_c12`  out  1 each  ACC→ALU enable, BR→ACC load, MR→ACC load, MBR→ACC load, ACC→MBR enable
- `o_alu_en`  out  1  ALU start/operate
- `o_alu_op`  out  ALU_OP_W  ALU operation
- `o_mem_rd`, `o_mem_wr`  out  1 each  memory request, level-held until ready or timeout
- `o_busy`  out  1  state ≠ IDLE
- `o_done`  out  1  one-cycle completion pulse
- `o_error`  out  1  one-cycle pulse: illegal opcode or memory timeout

## Operation
- Moore outputs decoded from the registered state; the opcode is latched on accept.
- Opcodes: STORE 0x01, LOAD 0x02, ADD 0x03, SUB 0x04, MPY 0x05, AND 0x06, OR 0x07, NOT 0x08, SHL 0x09, SHR 0x0A, MPYH 0x0B. Any other value is illegal.
- States: IDLE, MEM_RD, MEM_WR, LOAD_ACC, ALU_EXEC, ALU_WAIT, WB_BR, WB_MR, DONE, ERR.
- LOAD: MEM_RD → LOAD_ACC (`o_c11`) → DONE.
- STORE: MEM_WR (`o_c12` and `o_mem_wr` held) → DONE.
- ADD/SUB/AND/OR: MEM_RD → ALU_EXEC (`o_c7`, `o_alu_en`, `o_alu_op`) → WB_BR (`o_c9`) → DONE.
- NOT/SHL/SHR: ALU_EXEC → WB_BR → DONE (no memory access).
- MPY: MEM_RD → ALU_EXEC → ALU_WAIT (`o_c7` and `o_alu_op` held, `o_alu_en` low) until `i_alu_done` → WB_BR → DONE.
- MPYH: WB_MR (`o_c10`) → DONE.
- Illegal opcode: ERR (`o_error`) → IDLE with no done pulse.
- `o_alu_op` equals the opcode's low ALU_OP_W bits during ALU_EXEC/ALU_WAIT and is 0 otherwise.
- At most one of `o_c9`/`o_c10`/`o_c11` is high in any cycle. `o_c12` is never high together with any of them.

## Timing
- Reset: state IDLE, wait counter 0, every output 0. Reset mid-sequence aborts immediately; memory requests drop the cycle after reset is sampled.
- Accept: `i_start` high in IDLE at edge T0 puts the FSM in its first state during cycle T0+1.
- `i_start` while busy is ignored, with no queueing.
- MEM_RD/MEM_WR:
  - Request asserted on state entry.
  - Leaves the state on the edge where `i_mem_ready`=1; ready already high on entry gives a one-cycle dwell.
  - Wait counter resets on entry and increments each cycle ready is low.
  - At MEM_TIMEOUT cycles without ready the FSM goes to ERR. Request drops and `o_error` pulses the next cycle.
- ALU_WAIT has no timeout.
- Minimum latencies, accept edge to `o_done` cycle:
  - LOAD 3 cycles
  - STORE 2
  - ADD 4
  - NOT 3
  - MPYH 2
  - MPY 5 (with `i_alu_done` on the first ALU_WAIT cycle)
- DONE and ERR last exactly one cycle. A new `i_start` is accepted in the IDLE cycle that follows, giving back-to-back operation every (latency+1) cycles.

## Structure
- Package `acc_seq_pkg` holds:
  - opcode localparams
  - ALU op encodings
  - state enum
  - the `is_legal`/`needs_mem_rd`/`is_multicycle` helper functions
- One sub-module, `acc_seq_wait_timer`: the clearable MEM_TIMEOUT counter, with `clr`, `en` and `expired` ports.
- The FSM and output decode stay in `acc_sequencer`.

## Test plan
- Reset mid-MEM_RD (LOAD, ready held low 3 cycles, then `i_rst` for 1 cycle) → next cycle all outputs 0, `o_busy`=0, no `o_done`.
- LOAD 0x02 with ready on first MEM_RD cycle → `o_mem_rd` for 1 cycle, `o_c11` 1 cycle, `o_done` 3 cycles after accept; ACC model = MBR 0xBEEF.
- ADD 0x03 with ready delayed 2 cycles → `o_c7`/`o_alu_en` with `o_alu_op`=0x3 for 1 cycle, then `o_c9` for 1 cycle, `o_done` at accept+6.
- MPY 0x05 with `i_alu_done` after 4 ALU_WAIT cycles → `o_c7` high 5 consecutive cycles, then `o_c9`; `i_start` pulsed during ALU_WAIT is ignored.
- STORE with ready never asserted, MEM_TIMEOUT=16 → `o_mem_wr`/`o_c12` high 16 cycles, then `o_error` pulse, no `o_done`, IDLE.
- Illegal 0xFF, then MPYH 0x0B back-to-back → `o_error` pulse with no C-line activity, then `o_c10` 1 cycle and `o_done`. Assertion on every cycle: C9/C10/C11 one-hot-or-zero.
